rnn_step_sequencer: RTL and testbench

Sequencer that runs a multi-timestep RNN inference on one `RAM` + `RNN_Node` pair. It steps the `RAM` read port through timesteps 0..T-1 and gates `RNN_Node` through its clock-enable. It captures each step's `y_t`/`h_t`, feeds `h_t` back as the next step's hidden state, and emits a write-back stream of outputs. It sits between the top-level RNN wrapper's control inputs and the memory/processing-unit pair.

---
 rtl/rnn_step_sequencer.sv | 115 +++++++++++
 tb/tb_rnn_step_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_step_sequencer.sv
// Steps one RAM + RNN_Node pair through T timesteps, feeding each step's h_t back
// as the next hidden state and streaming the captured y_t values out for write-back.
module rnn_step_sequencer #(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_steps,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] readport,
    output logic              node_ce,
    input  logic              node_ce_out,
    input  logic [31:0]       node_y,
    input  logic [31:0]       node_h,
    output logic              h_sel,
    output logic [31:0]       h_fb,
    output logic              y_wr_en,
    output logic [ADDR_W-1:0] y_wr_addr,
    output logic [31:0]       y_wr_data,
    output logic [31:0]       Y
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FETCH, COMPUTE, WRITE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] t;
    logic [ADDR_W-1:0] t_last;
    logic [CNT_W-1:0]  cnt;

    // The timestep register doubles as the RAM read select.
    assign readport = t;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            t         <= '0;
            t_last    <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            node_ce   <= 1'b0;
            h_sel     <= 1'b0;
            h_fb      <= '0;
            y_wr_en   <= 1'b0;
            y_wr_addr <= '0;
            y_wr_data <= '0;
            Y         <= '0;
        end else begin
            done    <= 1'b0;
            y_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        t_last <= num_steps - ADDR_W'(1);
                        t      <= '0;
                        error  <= 1'b0;
                        h_sel  <= 1'b0;
                        busy   <= 1'b1;
                        if (num_steps == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    node_ce <= 1'b1;
                    cnt     <= CNT_W'(1);
                    state   <= COMPUTE;
                end
                COMPUTE: begin
                    if (node_ce_out) begin
                        Y         <= node_y;
                        h_fb      <= node_h;
                        y_wr_data <= node_y;
                        y_wr_addr <= t;
                        y_wr_en   <= 1'b1;
                        node_ce   <= 1'b0;
                        state     <= WRITE;
                    end else if (cnt == CNT_W'(TIMEOUT)) begin
                        // Abandon the run: no write, no done, error stays until next start.
                        error   <= 1'b1;
                        busy    <= 1'b0;
                        node_ce <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    h_sel <= 1'b1;
                    if (t == t_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        t     <= t + ADDR_W'(1);
                        state <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rnn_step_sequencer.sv
// Scoreboard bench: a run's expected writes and done timing are derived from the
// per-step latencies and pushed on issue; a monitor pops and compares them.
module tb_rnn_step_sequencer;
    localparam int ADDR_W  = 4;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] num_steps;
    logic              busy, done, error, node_ce, node_ce_out, h_sel, y_wr_en;
    logic [ADDR_W-1:0] readport, y_wr_addr;
    logic [31:0]       node_y, node_h, h_fb, y_wr_data, Y;

    rnn_step_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .num_steps(num_steps),
        .busy(busy), .done(done), .error(error), .readport(readport),
        .node_ce(node_ce), .node_ce_out(node_ce_out), .node_y(node_y), .node_h(node_h),
        .h_sel(h_sel), .h_fb(h_fb), .y_wr_en(y_wr_en), .y_wr_addr(y_wr_addr),
        .y_wr_data(y_wr_data), .Y(Y)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    // Per-step node behaviour: latency k (0 = never responds), y_t and h_t.
    int          ks[16];
    logic [31:0] ys[16];
    logic [31:0] hs[16];

    int   ns;        // step index the emulated node is working on
    int   ce_cnt;    // consecutive node_ce cycles already elapsed in this step
    int   cyc;
    int   ce_seen;
    int   checks;
    int   failures;

    wr_t  exp_wr[$];
    int   exp_done[$];
    int   exp_end, exp_ce, ce_base;
    logic exp_err;
    logic [31:0] last_y, last_h;

    assign node_ce_out = node_ce && (ns < 16) && (ks[ns[3:0]] != 0) && (ce_cnt + 1 == ks[ns[3:0]]);
    assign node_y      = (ns < 16) ? ys[ns[3:0]] : 32'h0;
    assign node_h      = (ns < 16) ? hs[ns[3:0]] : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Issue a run of T steps using ks/ys/hs and record what it must produce.
    task automatic launch(input int T);
        int acc;
        acc     = 0;
        exp_err = 1'b0;
        exp_ce  = 0;
        ce_base = ce_seen;
        ns      = 0;
        for (int i = 0; i < T; i++) begin
            if (ks[i] == 0) begin
                exp_err = 1'b1;
                exp_ce += TIMEOUT;
                exp_end = cyc + acc + TIMEOUT + 2;
                break;
            end
            acc    += ks[i] + 2;
            exp_ce += ks[i];
            exp_wr.push_back('{addr: i, data: ys[i], cyc: cyc + acc});
            last_y = ys[i];
            last_h = hs[i];
        end
        if (!exp_err) begin
            exp_done.push_back(cyc + acc + 1);
            exp_end = cyc + acc + 2;
        end
        num_steps = ADDR_W'(T);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_end_cycle"}, cyc, exp_end);
        chk({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
        chk({tag, "_h_fb"}, h_fb, last_h);
        chk({tag, "_Y"}, Y, last_y);
        chk({tag, "_node_ce_cycles"}, ce_seen - ce_base, exp_ce);
        chk({tag, "_writes_left"}, exp_wr.size(), 0);
        chk({tag, "_done_left"}, exp_done.size(), 0);
        @(negedge clk);
    endtask

    task automatic fill_random(input int T);
        for (int i = 0; i < T; i++) begin
            ks[i] = $urandom_range(1, 5);
            ys[i] = $urandom;
            hs[i] = $urandom;
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_error"}, {31'b0, error}, 0);
        chk({tag, "_node_ce"}, {31'b0, node_ce}, 0);
        chk({tag, "_y_wr_en"}, {31'b0, y_wr_en}, 0);
        chk({tag, "_h_sel"}, {31'b0, h_sel}, 0);
        chk({tag, "_readport"}, {28'b0, readport}, 0);
        chk({tag, "_y_wr_addr"}, {28'b0, y_wr_addr}, 0);
        chk({tag, "_h_fb"}, h_fb, 0);
        chk({tag, "_Y"}, Y, 0);
        chk({tag, "_y_wr_data"}, y_wr_data, 0);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; ce_seen = 0; ns = 0; ce_cnt = 0;
        last_y = 0; last_h = 0; exp_end = 0; exp_ce = 0; ce_base = 0; exp_err = 1'b0;
        for (int i = 0; i < 16; i++) begin ks[i] = 0; ys[i] = 0; hs[i] = 0; end
        reset = 1'b1; start = 1'b0; num_steps = '0;

        fork
            forever begin
                @(posedge clk);
                cyc <= cyc + 1;
            end
            // Emulated node: values sampled mid-cycle, applied at the edge.
            forever begin
                logic ce_s, out_s;
                @(negedge clk);
                ce_s  = node_ce;
                out_s = node_ce_out;
                @(posedge clk);
                ce_cnt <= ce_s ? ce_cnt + 1 : 0;
                if (out_s) ns <= ns + 1;
            end
            // Monitor / scoreboard.
            forever begin
                @(negedge clk);
                if (node_ce) begin
                    ce_seen++;
                    chk("h_sel_in_step", {31'b0, h_sel}, {31'b0, ns != 0});
                end
                if (y_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", 1, 0);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        chk("wr_addr", {28'b0, y_wr_addr}, e.addr);
                        chk("wr_data", y_wr_data, e.data);
                        chk("wr_cycle", cyc, e.cyc);
                    end
                end
                if (done) begin
                    if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
                    else chk("done_cycle", cyc, exp_done.pop_front());
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);

        // Single step, k=3.
        ks[0] = 3; ys[0] = 32'h11; hs[0] = 32'h22;
        launch(1); wait_end("single");

        // Four steps, k=2, h = step+1.
        for (int i = 0; i < 4; i++) begin ks[i] = 2; ys[i] = $urandom; hs[i] = i + 1; end
        launch(4); wait_end("four");

        // T=0: straight to done.
        launch(0); wait_end("zero");

        // Timeout in step 0 of T=2, then a normal run clears error.
        ks[0] = 0; ks[1] = 2;
        launch(2); wait_end("timeout");
        fill_random(2);
        launch(2); wait_end("after_timeout");

        // Randomised runs.
        for (int r = 0; r < 6; r++) begin
            int T;
            T = $urandom_range(1, 6);
            fill_random(T);
            launch(T); wait_end("rand");
        end

        // Largest T.
        fill_random(15);
        for (int i = 0; i < 15; i++) ks[i] = 1;
        launch(15); wait_end("max_t");

        // start pulsed mid-run is ignored.
        fill_random(2);
        ks[0] = 4;
        launch(2);
        begin
            int n;
            n = 0;
            while (!node_ce && n < 50) begin @(negedge clk); n++; end
        end
        num_steps = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("mid_start");

        // Reset during step 1 of T=3.
        for (int i = 0; i < 3; i++) begin ks[i] = 3; ys[i] = $urandom; hs[i] = $urandom; end
        launch(3);
        begin
            int n;
            n = 0;
            while (!(node_ce && ns == 1) && n < 100) begin @(negedge clk); n++; end
            chk("reached_step1", {31'b0, node_ce && ns == 1}, 1);
        end
        reset = 1'b1;
        #1;
        chk_reset_values("async_reset");
        exp_wr.delete();
        exp_done.delete();
        last_y = 0; last_h = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_reset_busy", {31'b0, busy}, 0);
        fill_random(1);
        launch(1); wait_end("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
